spi_target_sync: RTL and testbench
==================================

Name: spi_target_sync

Overview:
- Synthesizable SPI slave (responder) for the SPI bus; the single-clock counterpart to the bus master.
- Oversamples the bus pins (sclk, mosi, ss_n) in the system clock domain.
- Deserializes frames of DATA_W bits from mosi and serializes a response onto miso.
- Presents received data and accepts transmit data through valid/ready handshakes to on-chip logic.

Parameters:
- DATA_W, 8, frame length in bits; shift order is LSB first.
- TX_FILL, 0, value sent on miso when no transmit word is buffered at frame start.
- SYNC_STAGES, 2, synchronizer flops on sclk, mosi and ss_n (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sclk  input  1  SPI serial clock from master.
- mosi  input  1  SPI master-out data.
- ss_n  input  1  slave select, active-low.
- miso  output  1  SPI master-in data; valid only while miso_oe=1.
- miso_oe  output  1  miso drive enable; the pad wrapper tri-states miso when 0.
- tx_data  input  DATA_W  next response word.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  DATA_W  last received frame.
- rx_valid  output  1  rx_data holds an unconsumed frame.
- rx_ready  input  1  consumer accepts rx_data.
- busy  output  1  frame in progress (selected and bit count != 0).
- rx_overrun  output  1  one-cycle pulse: a frame completed while rx_valid=1 and rx_ready=0.
- tx_underrun  output  1  one-cycle pulse: TX_FILL was loaded because the buffer was empty.
- frame_abort  output  1  one-cycle pulse: ss_n deasserted mid-frame.

Behaviour:
- **Reset:** asynchronous; clears all registers.
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, all pulse outputs 0.
  - Bit count 0, state IDLE, synchronizers load sclk=0, mosi=0, ss_n=1.
  - Reset asserted mid-frame discards the partial frame and the transmit buffer; no pulses are generated.
- **Edge detection:** sclk, mosi and ss_n pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronizer stage with one extra registered copy.
  - Master requirement: SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods.
- **Transmit buffer:** one DATA_W register plus a full flag; tx_ready = !full.
  - Write happens when tx_valid && tx_ready.
  - A simultaneous write and frame-start load in the same cycle loads the incoming tx_data directly into the shift register; the buffer stays empty.
- **State machine:** IDLE, SHIFT.
  - IDLE -> SHIFT on synchronized ss_n falling. In that cycle:
    - load tx_sr from the buffer (clear full), or load TX_FILL and pulse tx_underrun;
    - clear bit count; miso_oe=1; miso = loaded bit 0.
  - SHIFT, sclk rising: if count != 0, tx_sr shifts right one place and miso = new tx_sr[0]. If count == 0, no shift, so bit 0 is held for the first sample.
  - SHIFT, sclk falling: rx_sr <= {mosi_sync, rx_sr[DATA_W-1:1]}; count++.
  - Frame completes when count reaches DATA_W on a falling edge. In that cycle:
    - if !rx_valid || rx_ready: rx_data <= assembled word, rx_valid=1; otherwise drop the word and pulse rx_overrun;
    - count returns to 0 and tx_sr reloads from the buffer (or TX_FILL + tx_underrun), which supports back-to-back frames without deselect.
  - SHIFT -> IDLE on synchronized ss_n rising: miso_oe=0, miso=0.
    - If count != 0, pulse frame_abort and discard the partial rx_sr.
    - A word already loaded into tx_sr is lost; it is not returned to the buffer.
  - ss_n rising in the same cycle as a completing falling edge: the frame completes first (rx_valid set), then the block goes to IDLE with no abort.
- **rx handshake:** rx_valid clears on rx_valid && rx_ready unless a new frame completes in that same cycle, in which case rx_valid stays 1 with the new data.
- **Latency:** rx_valid rises SYNC_STAGES+2 clk cycles after the final SCLK falling edge at the pin. miso updates SYNC_STAGES+2 cycles after the SCLK rising edge.
- **Edge cases:** sclk edges while in IDLE are ignored. busy = (state==SHIFT) && count != 0.

Test Plan:
1. Reset held, then released with ss_n=1 -> miso_oe=0, tx_ready=1, rx_valid=0, all pulses 0.
2. Write tx_data=0xA5; master sends 0x3C LSB first, 8 rise/fall pairs, half-period 8 clk -> master samples 0xA5 on miso; rx_data=0x3C; rx_valid rises 4 cycles after the 8th fall; tx_ready=1 after load.
3. No tx write; master sends 0xFF -> tx_underrun single pulse at select; miso carries 0x00; rx_data=0xFF.
4. Two back-to-back frames 0x11, 0x22 with rx_ready=0 throughout -> rx_data stays 0x11; rx_overrun pulses once at end of second frame; rx_valid stays 1.
5. ss_n deasserted after 3 bits -> frame_abort one pulse; rx_valid unchanged; miso_oe=0; the next full frame 0x5A is received correctly.
6. Assert rst_n=0 after 4 bits of a frame with tx buffer full -> all outputs at reset values immediately; tx_ready=1 after release; no pulses.

Source files
------------

// File: rtl/spi_target_sync.sv
// SPI target that oversamples sclk/mosi/ss_n in the clk domain and exchanges
// DATA_W-bit LSB-first frames through a one-word tx buffer and an rx holding register.

module spi_target_sync_cdc #(
  parameter int             W      = 3,
  parameter int             STAGES = 2,
  parameter logic [W-1:0]   RST    = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [STAGES-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pipe <= {STAGES{RST}};
    else        r_pipe <= {r_pipe[STAGES-2:0], i_d};
  end

  assign o_q = r_pipe[STAGES-1];
endmodule

module spi_target_sync #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] TX_FILL     = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0]        w_q;
  logic              w_sclk, w_mosi, w_ss_n;
  logic              r_sclk_d, r_ss_d;
  logic              r_rise, r_fall, r_ss_fall, r_ss_rise, r_mosi;
  state_t            r_state, w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_tx_sr, r_rx_sr, r_txbuf, r_rx_data;
  logic              r_full, r_rx_valid, r_miso, r_oe;
  logic              r_ovr, r_und, r_abt;
  logic              w_start, w_reload, w_load, w_shift, w_sample, w_done, w_abort, w_tx_wr;
  logic [DATA_W-1:0] w_load_word, w_rx_nx;

  spi_target_sync_cdc #(.W(3), .STAGES(SYNC_STAGES), .RST(3'b100)) u_cdc (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  ({ss_n, mosi, sclk}),
    .o_q  (w_q)
  );

  assign w_sclk = w_q[0];
  assign w_mosi = w_q[1];
  assign w_ss_n = w_q[2];

  // Edge strobes are registered together with mosi so the sample lines up with the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d  <= 1'b0;
      r_ss_d    <= 1'b1;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_ss_fall <= 1'b0;
      r_ss_rise <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_sclk_d  <= w_sclk;
      r_ss_d    <= w_ss_n;
      r_rise    <= w_sclk & ~r_sclk_d;
      r_fall    <= ~w_sclk & r_sclk_d;
      r_ss_fall <= ~w_ss_n & r_ss_d;
      r_ss_rise <= w_ss_n & ~r_ss_d;
      r_mosi    <= w_mosi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_reload   = 1'b0;
    w_shift    = 1'b0;
    w_sample   = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ss_fall) begin
          w_state_nx = SHIFT;
          w_start    = 1'b1;
        end
      end
      SHIFT: begin
        w_sample = r_fall;
        w_done   = r_fall && (r_cnt == CW'(DATA_W - 1));
        w_shift  = r_rise && (r_cnt != '0);
        if (r_ss_rise) begin
          // A frame finishing on the deselect cycle completes cleanly; no reload.
          w_state_nx = IDLE;
          w_shift    = 1'b0;
          w_abort    = !w_done && ((r_cnt != '0) || r_fall);
        end else begin
          w_reload = w_done;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_load      = w_start | w_reload;
  assign w_tx_wr     = tx_valid & ~r_full;
  assign w_load_word = r_full ? r_txbuf : (tx_valid ? tx_data : TX_FILL);
  assign w_rx_nx     = {r_mosi, r_rx_sr[DATA_W-1:1]};

  // A write racing a load bypasses the buffer straight into the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_txbuf <= '0;
    end else if (w_load && r_full) begin
      r_full <= 1'b0;
    end else if (w_tx_wr && !w_load) begin
      r_full  <= 1'b1;
      r_txbuf <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_cnt      <= '0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_ovr      <= 1'b0;
      r_und      <= 1'b0;
      r_abt      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      r_und <= 1'b0;
      r_abt <= w_abort;

      if (w_load) begin
        r_tx_sr <= w_load_word;
        r_miso  <= w_load_word[0];
        r_oe    <= 1'b1;
        r_cnt   <= '0;
        r_und   <= !r_full && !tx_valid;
      end else if (w_shift) begin
        r_tx_sr <= r_tx_sr >> 1;
        r_miso  <= r_tx_sr[1];
      end

      if (w_sample && !w_done) begin
        r_rx_sr <= w_rx_nx;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_done) r_cnt <= '0;

      if (w_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= w_rx_nx;
        r_rx_valid <= 1'b1;
      end else begin
        if (w_done)   r_ovr      <= 1'b1;
        if (rx_ready) r_rx_valid <= 1'b0;
      end

      if (r_state == SHIFT && w_state_nx == IDLE) begin
        r_oe   <= 1'b0;
        r_miso <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_oe;
  assign tx_ready    = ~r_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state == SHIFT) && (r_cnt != '0);
  assign rx_overrun  = r_ovr;
  assign tx_underrun = r_und;
  assign frame_abort = r_abt;
endmodule

// File: tb/tb_spi_target_sync.sv
// Bench for spi_target_sync: a bit-banged SPI master plus a frame-level model
// of the tx buffer (what word each load should carry and which loads underrun).

module tb_spi_target_sync;
  localparam int        H    = 8;
  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic       miso, miso_oe, tx_ready, rx_valid, busy;
  logic       rx_overrun, tx_underrun, frame_abort;
  logic       tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_data;

  int n_checks = 0, n_errors = 0;
  int c_und = 0, c_ovr = 0, c_abt = 0;

  logic [7:0] m_tx = 8'h00;
  bit         m_full = 1'b0;
  int         m_und = 0;

  spi_target_sync #(.DATA_W(8), .TX_FILL(FILL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_underrun) c_und++;
    if (rx_overrun)  c_ovr++;
    if (frame_abort) c_abt++;
  end

  // Every frame start and every completed frame (while still selected) pulls one word.
  function automatic logic [7:0] tx_load();
    if (m_full) begin
      m_full = 1'b0;
      return m_tx;
    end
    m_und++;
    return FILL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [7:0] w);
    int k = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && k < 40) begin tick(); k++; end
    if (!tx_ready) begin
      n_checks++; n_errors++;
      $display("FAIL write_tx_timeout: tx_ready stayed 0 for %0d cycles", k);
    end
    tick();
    tx_valid = 1'b0;
    m_tx   = w;
    m_full = 1'b1;
  endtask

  task automatic sel();
    ss_n = 1'b0;
    repeat (H) tick();
  endtask

  task automatic desel();
    ss_n = 1'b1;
    repeat (H) tick();
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  // Master: drive mosi with the rising edge, sample miso just before the falling edge.
  task automatic frame(input logic [7:0] w, input int nbits, output logic [7:0] mw, output int lat);
    mw  = 8'h00;
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[i];
      sclk = 1'b1;
      repeat (H) tick();
      mw[i] = miso;
      sclk = 1'b0;
      for (int j = 1; j <= H; j++) begin
        tick();
        if (i == nbits - 1 && lat < 0 && rx_valid) lat = j;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({miso_oe, miso, tx_ready, rx_valid, busy} !== 5'b00100) begin
      n_errors++;
      $display("FAIL reset_hold: oe/miso/tx_ready/rx_valid/busy=%b expected 00100",
               {miso_oe, miso, tx_ready, rx_valid, busy});
    end
    rst_n = 1'b1;
    repeat (6) tick();
    n_checks++;
    if ({miso_oe, tx_ready, rx_valid, busy, rx_data} !== {4'b0100, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_release: oe=%b tx_ready=%b rx_valid=%b busy=%b rx_data=%h",
               miso_oe, tx_ready, rx_valid, busy, rx_data);
    end
    n_checks++;
    if (c_und + c_ovr + c_abt !== 0) begin
      n_errors++;
      $display("FAIL reset_pulses: und=%0d ovr=%0d abt=%0d expected 0", c_und, c_ovr, c_abt);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_m, mw;
    int lat;
    write_tx(8'hA5);
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++; $display("FAIL basic_buf_full: tx_ready=%b expected 0", tx_ready);
    end
    exp_m = tx_load();
    sel();
    n_checks++;
    if ({tx_ready, miso_oe} !== 2'b11) begin
      n_errors++; $display("FAIL basic_load: tx_ready=%b miso_oe=%b expected 1 1", tx_ready, miso_oe);
    end
    frame(8'h3C, 8, mw, lat);
    void'(tx_load());
    n_checks++;
    if (mw !== exp_m) begin
      n_errors++; $display("FAIL basic_miso: got %h expected %h", mw, exp_m);
    end
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      n_errors++; $display("FAIL basic_rx: rx_valid=%b rx_data=%h expected 1 3c", rx_valid, rx_data);
    end
    n_checks++;
    if (lat !== 4) begin
      n_errors++; $display("FAIL basic_latency: rx_valid rose after %0d cycles expected 4", lat);
    end
    desel();
    n_checks++;
    if (miso_oe !== 1'b0 || c_und !== m_und) begin
      n_errors++; $display("FAIL basic_end: miso_oe=%b underruns=%0d expected 0 %0d", miso_oe, c_und, m_und);
    end
    consume();
  endtask

  task automatic test_underrun();
    logic [7:0] exp_m, mw, w;
    int lat;
    exp_m = tx_load();
    sel();
    n_checks++;
    if (c_und !== m_und) begin
      n_errors++; $display("FAIL underrun_pulse: count=%0d expected %0d", c_und, m_und);
    end
    w = 8'hFF;
    frame(w, 8, mw, lat);
    void'(tx_load());
    desel();
    n_checks++;
    if (mw !== exp_m || rx_data !== w) begin
      n_errors++; $display("FAIL underrun_data: miso=%h rx_data=%h expected %h %h", mw, rx_data, exp_m, w);
    end
    consume();
  endtask

  task automatic test_random();
    logic [7:0] w_rx, w_tx, exp_m, mw;
    int lat;
    for (int it = 0; it < 5; it++) begin
      w_rx = 8'($urandom);
      w_tx = 8'($urandom);
      if ($urandom_range(0, 1) == 1) write_tx(w_tx);
      exp_m = tx_load();
      sel();
      frame(w_rx, 8, mw, lat);
      void'(tx_load());
      desel();
      n_checks++;
      if (mw !== exp_m || rx_data !== w_rx || rx_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL random_%0d: miso=%h rx_data=%h rx_valid=%b expected %h %h 1",
                 it, mw, rx_data, rx_valid, exp_m, w_rx);
      end
      n_checks++;
      if (c_und !== m_und) begin
        n_errors++; $display("FAIL random_und_%0d: count=%0d expected %0d", it, c_und, m_und);
      end
      consume();
      n_checks++;
      if (rx_valid !== 1'b0) begin
        n_errors++; $display("FAIL random_consume_%0d: rx_valid=%b expected 0", it, rx_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1, e2, mw1, mw2;
    int lat, ovr0;
    ovr0 = c_ovr;
    e1 = tx_load();
    sel();
    frame(8'h11, 8, mw1, lat);
    e2 = tx_load();
    frame(8'h22, 8, mw2, lat);
    void'(tx_load());
    desel();
    n_checks++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      n_errors++; $display("FAIL b2b_hold: rx_data=%h rx_valid=%b expected 11 1", rx_data, rx_valid);
    end
    n_checks++;
    if (c_ovr - ovr0 !== 1) begin
      n_errors++; $display("FAIL b2b_overrun: pulses=%0d expected 1", c_ovr - ovr0);
    end
    n_checks++;
    if (mw1 !== e1 || mw2 !== e2 || c_und !== m_und) begin
      n_errors++; $display("FAIL b2b_tx: miso=%h,%h und=%0d expected %h,%h %0d", mw1, mw2, c_und, e1, e2, m_und);
    end
    consume();
  endtask

  task automatic test_abort();
    logic [7:0] mw;
    int lat, abt0;
    abt0 = c_abt;
    void'(tx_load());
    sel();
    frame(8'h77, 8, mw, lat);
    void'(tx_load());
    desel();
    void'(tx_load());
    sel();
    frame(8'hE3, 3, mw, lat);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL abort_busy: busy=%b expected 1", busy);
    end
    desel();
    n_checks++;
    if (c_abt - abt0 !== 1 || miso_oe !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_pulse: pulses=%0d oe=%b busy=%b expected 1 0 0", c_abt - abt0, miso_oe, busy);
    end
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin
      n_errors++; $display("FAIL abort_rx: rx_valid=%b rx_data=%h expected 1 77", rx_valid, rx_data);
    end
    consume();
    void'(tx_load());
    sel();
    frame(8'h5A, 8, mw, lat);
    void'(tx_load());
    desel();
    n_checks++;
    if (rx_data !== 8'h5A || rx_valid !== 1'b1 || c_abt - abt0 !== 1) begin
      n_errors++; $display("FAIL abort_next: rx_data=%h rx_valid=%b aborts=%0d expected 5a 1 1", rx_data, rx_valid, c_abt - abt0);
    end
    n_checks++;
    if (c_und !== m_und) begin
      n_errors++; $display("FAIL abort_und: count=%0d expected %0d", c_und, m_und);
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mw;
    int lat, u0, o0, a0;
    void'(tx_load());
    sel();
    write_tx(8'($urandom));
    frame(8'($urandom), 4, mw, lat);
    n_checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_pre: tx_ready=%b busy=%b expected 0 1", tx_ready, busy);
    end
    u0 = c_und; o0 = c_ovr; a0 = c_abt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({miso_oe, miso, tx_ready, rx_valid, busy, rx_data} !== {5'b00100, 8'h00}) begin
      n_errors++;
      $display("FAIL rstmid_async: oe=%b miso=%b tx_ready=%b rx_valid=%b busy=%b rx_data=%h",
               miso_oe, miso, tx_ready, rx_valid, busy, rx_data);
    end
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    m_full = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * H) tick();
    n_checks++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || miso_oe !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_release: tx_ready=%b rx_valid=%b oe=%b expected 1 0 0", tx_ready, rx_valid, miso_oe);
    end
    n_checks++;
    if (c_und !== u0 || c_ovr !== o0 || c_abt !== a0) begin
      n_errors++; $display("FAIL rstmid_pulses: und/ovr/abt delta=%0d/%0d/%0d expected 0/0/0",
                           c_und - u0, c_ovr - o0, c_abt - a0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
